// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and types shared by the 8N1 UART receiver slice.
//   B115200    : clk cycles per bit at 115200 baud from a 12 MHz clock
//   DATA_BITS  : payload bits per frame
//   uart_state_t : receiver FSM states
package uart_rx_pkg;

    localparam int B115200   = 104;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte outputs of the UART receiver.
//   rx        : serial line, idle high (driven by the line side)
//   data      : last correctly framed byte
//   rcv       : one-cycle strobe, data updated
//   frame_err : one-cycle strobe, stop bit sampled low
// Modports: slave = the receiver, master = whatever drives the line and
// consumes the bytes.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 rcv;
    logic                 frame_err;

    modport master (output rx, input data, input rcv, input frame_err);
    modport slave  (input rx, output data, output rcv, output frame_err);

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line.
//   clk  : system clock
//   rst  : synchronous active-high reset, both flops go to the idle level 1
//   rx   : asynchronous serial input
//   rx_s : synchronized copy (second flop)
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic rx_meta;

    // Two back-to-back flops; resetting to 1 keeps a reset from looking
    // like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampling rx with a cycle counter
// (clock enable style, no derived clock).
//   M         : clk cycles per bit, M >= 4
//   clk       : system clock
//   rst       : synchronous active-high reset; aborts a frame silently
//   bus.rx    : serial line, idle high
//   bus.data  : last correctly framed byte, LSB received first
//   bus.rcv   : one-cycle strobe when data updates
//   bus.frame_err : one-cycle strobe when the stop bit is sampled low
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int M = B115200
) (
    input  logic clk,
    input  logic rst,
    uart_rx_if.slave bus
);

    localparam int CW = $clog2(M);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(M / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(M - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    uart_state_t          state_next;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] data_q;
    logic                 rcv_q;
    logic                 err_q;
    logic                 shift_en;
    logic                 rcv_set;
    logic                 err_set;
    logic                 cnt_run;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (bus.rx),
        .rx_s (rx_s)
    );

    // State register for the frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. START samples mid start bit to reject glitches;
    // DATA and STOP sample one full bit later each, i.e. at bit centres.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        rcv_set    = 1'b0;
        err_set    = 1'b0;
        cnt_run    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                cnt_run = 1'b1;
                if (cnt == HALF_LAST) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_run = 1'b1;
                if (cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                cnt_run = 1'b1;
                if (cnt == BIT_LAST) begin
                    if (rx_s) begin
                        rcv_set    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: the bit timer restarts on every state change, bits shift
    // in from the MSB side so the first (LSB) bit ends up in bit 0, and the
    // strobes are registered so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shifter <= '0;
            data_q  <= '0;
            rcv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rcv_q <= rcv_set;
            err_q <= err_set;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + CW'(1);
            end
            if (state == START && state_next == DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + BW'(1);
            end
            if (shift_en) begin
                shifter <= {rx_s, shifter[DATA_BITS-1:1]};
            end
            if (rcv_set) begin
                data_q <= shifter;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.rcv       = rcv_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at M=16. Frames are driven
// bit by bit on the line; a monitor logs every rcv byte and cycle and
// counts frame_err pulses, and the bench compares that log with the bytes
// it expects from the frames it sent.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int M = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(.M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_count = 0;
    int both_high = 0;
    int logged = 0;
    logic [7:0] rcv_q[$];
    int         rcv_cyc_q[$];
    logic [7:0] exp_q[$];

    // Cycle counter used to time rcv pulses against the drive point.
    always @(posedge clk) cyc++;

    // Monitor: one entry per rcv-high cycle, so a stretched strobe shows up
    // as an extra byte; frame_err counted per high cycle for the same reason.
    always @(negedge clk) begin
        if (bus.rcv === 1'b1) begin
            rcv_q.push_back(bus.data);
            rcv_cyc_q.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) err_count++;
        if (bus.rcv === 1'b1 && bus.frame_err === 1'b1) both_high++;
    end

    // Watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame starting at the current negedge, ends on a negedge.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                 output int start_cyc);
        start_cyc = cyc;
        bus.rx = 1'b0;
        repeat (M) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (M) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (M) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        bus.rx = 1'b1;
        repeat (n * M) @(negedge clk);
    endtask

    // Compares received bytes with the expected list, new entries only.
    task automatic compareLog(input string tag);
        checkOutput({tag, "_count"}, rcv_q.size(), exp_q.size());
        for (int i = logged; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checkOutput({tag, "_byte"}, rcv_q[i], exp_q[i]);
        end
        logged = exp_q.size();
    endtask

    function automatic int cycAt(input int idx);
        if (idx >= 0 && idx < rcv_cyc_q.size()) return rcv_cyc_q[idx];
        return -1;
    endfunction

    initial begin
        int s;
        int n0;
        logic [7:0] b;
        logic [7:0] v77;
        bus.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_data", bus.data, 8'h00);
        checkOutput("reset_rcv", bus.rcv, 1'b0);
        checkOutput("reset_ferr", bus.frame_err, 1'b0);
        idleBits(2);

        // 'C' with a 3-bit idle gap; rcv timed from the start-bit drive.
        applyStimulus(8'h43, 1'b1, s);
        exp_q.push_back(8'h43);
        idleBits(3);
        compareLog("c43");
        checkOutput("c43_latency", cycAt(rcv_cyc_q.size() - 1), s + 3 + M / 2 + 9 * M);
        checkOutput("c43_ferr", err_count, 0);

        // Three frames with zero idle bits between them.
        n0 = rcv_cyc_q.size();
        applyStimulus(8'h00, 1'b1, s);
        applyStimulus(8'hFF, 1'b1, s);
        applyStimulus(8'hA5, 1'b1, s);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA5);
        idleBits(2);
        compareLog("b2b");
        checkOutput("b2b_gap1", cycAt(n0 + 1) - cycAt(n0), 10 * M);
        checkOutput("b2b_gap2", cycAt(n0 + 2) - cycAt(n0 + 1), 10 * M);

        // Short low glitch is ignored, then a normal frame.
        bus.rx = 1'b0;
        repeat (M / 2 - 2) @(negedge clk);
        idleBits(2);
        compareLog("glitch");
        checkOutput("glitch_ferr", err_count, 0);
        applyStimulus(8'h5A, 1'b1, s);
        exp_q.push_back(8'h5A);
        idleBits(2);
        compareLog("after_glitch");

        // Bad stop bit: one frame_err, data keeps the last good byte.
        applyStimulus(8'h81, 1'b0, s);
        idleBits(2);
        checkOutput("bad_stop_ferr", err_count, 1);
        checkOutput("bad_stop_hold", bus.data, exp_q[exp_q.size() - 1]);
        compareLog("bad_stop");
        applyStimulus(8'h3C, 1'b1, s);
        exp_q.push_back(8'h3C);
        idleBits(2);
        compareLog("after_bad_stop");

        // Line held low for 30 bit times: a single frame_err.
        bus.rx = 1'b0;
        repeat (30 * M) @(negedge clk);
        checkOutput("break_ferr", err_count, 2);
        idleBits(2);
        checkOutput("break_release_ferr", err_count, 2);
        applyStimulus(8'h11, 1'b1, s);
        exp_q.push_back(8'h11);
        idleBits(2);
        compareLog("after_break");

        // Reset pulse in the middle of data bit 4 of 0x77.
        v77 = 8'h77;
        bus.rx = 1'b0;
        repeat (M) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = v77[i];
            repeat (M) @(negedge clk);
        end
        bus.rx = v77[4];
        repeat (M / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_data", bus.data, 8'h00);
        checkOutput("rst_mid_rcv", bus.rcv, 1'b0);
        repeat (M - M / 2 - 1) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            bus.rx = v77[i];
            repeat (M) @(negedge clk);
        end
        bus.rx = 1'b1;
        repeat (M) @(negedge clk);
        compareLog("rst_mid_frame");
        checkOutput("rst_mid_ferr", err_count, 2);
        // After the reset, the low data bit 7 reads as a fresh start bit
        // followed by an all-high line, so an 0xFF frame is delivered.
        exp_q.push_back(8'hFF);
        idleBits(12);
        compareLog("rst_trailing");
        applyStimulus(8'h77, 1'b1, s);
        exp_q.push_back(8'h77);
        idleBits(2);
        compareLog("after_rst");

        // Random bytes with random idle gaps of 0..2 bits.
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            applyStimulus(b, 1'b1, s);
            exp_q.push_back(b);
            idleBits($urandom_range(0, 2));
        end
        idleBits(2);
        compareLog("random");

        // Transmitter-style stream of 'C' frames with one idle bit.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'h43, 1'b1, s);
            exp_q.push_back(8'h43);
            idleBits(1);
        end
        idleBits(2);
        compareLog("stream_c");

        checkOutput("strobes_exclusive", both_high, 0);
        checkOutput("ferr_total", err_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
